// File: rtl/food_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : food_spawner
//  Description : Food placement and eat detection for the snake game.
//                A free-running 8-bit LFSR proposes food cells. In PLACE a
//                candidate is accepted when it lies inside the grid and is not
//                under the snake head. In ACTIVE a tick with the head on the
//                food pulses eaten, bumps the saturating score and returns to
//                PLACE.
//  Ports       : clk, reset (sync, active-high)
//                tick           - game-step strobe, head valid this cycle
//                headX, headY   - snake head coordinates
//                foodX, foodY   - registered food coordinates
//                foodValid      - food currently placed
//                eaten          - one-cycle pulse on consumption
//                score          - foods eaten, saturating at 255
//  Revision    : 1.0 - initial release
// ============================================================================
module food_spawner #(
   parameter logic [7:0] SEED   = 8'hA5,
   parameter int         GRID_W = 16,
   parameter int         GRID_H = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [3:0] headX,
   input  logic [3:0] headY,
   output logic [3:0] foodX,
   output logic [3:0] foodY,
   output logic       foodValid,
   output logic       eaten,
   output logic [7:0] score
);

   // An all-zero LFSR would lock up, so a zero seed is forced to 1.
   localparam logic [7:0] c_seedLoad = (SEED == 8'h00) ? 8'h01 : SEED;
   // Grid sizes may be 16, so compare in 5 bits.
   localparam logic [4:0] c_gridW    = 5'(GRID_W);
   localparam logic [4:0] c_gridH    = 5'(GRID_H);

   typedef enum logic [0:0] {
      PLACE  = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t     r_state;
   logic [7:0] r_lfsr;

   logic       w_feedback;
   logic [3:0] w_candX;
   logic [3:0] w_candY;
   logic       w_inGrid;
   logic       w_onHead;
   logic       w_candOk;
   logic       w_hitFood;

   // Taps 8,6,5,4 give a maximal-length (255-state) sequence.
   assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   // Candidate comes from the pre-advance LFSR value.
   assign w_candX   = r_lfsr[7:4];
   assign w_candY   = r_lfsr[3:0];
   assign w_inGrid  = ({1'b0, w_candX} < c_gridW) && ({1'b0, w_candY} < c_gridH);
   // Same-cycle head compare: a head stepping onto the candidate blocks it.
   assign w_onHead  = (w_candX == headX) && (w_candY == headY);
   assign w_candOk  = w_inGrid && !w_onHead;
   assign w_hitFood = tick && (headX == foodX) && (headY == foodY);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr    <= c_seedLoad;
         r_state   <= PLACE;
         foodX     <= 4'd0;
         foodY     <= 4'd0;
         foodValid <= 1'b0;
         eaten     <= 1'b0;
         score     <= 8'd0;
      end else begin
         // Free-running so player timing perturbs the placement sequence.
         r_lfsr <= {r_lfsr[6:0], w_feedback};
         eaten  <= 1'b0;
         case (r_state)
            PLACE: begin
               // tick is ignored here: there is no valid food to eat yet.
               if (w_candOk) begin
                  foodX     <= w_candX;
                  foodY     <= w_candY;
                  foodValid <= 1'b1;
                  r_state   <= ACTIVE;
               end
            end
            ACTIVE: begin
               // foodX/foodY keep their stale values until the next accept.
               if (w_hitFood) begin
                  eaten     <= 1'b1;
                  foodValid <= 1'b0;
                  r_state   <= PLACE;
                  if (score != 8'hFF) begin
                     score <= score + 8'd1;
                  end
               end
            end
            default: begin
               r_state <= PLACE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_food_spawner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_food_spawner
//  Description : Self-checking bench for food_spawner. Two instances run in
//                lockstep: a 16x16 grid and a 10x12 grid, each tracked by a
//                behavioural model of the game rules. A hand-derived vector
//                table covers reset, placement, eat and reset-wins cases;
//                randomized play and a score-saturation run follow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_food_spawner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: 16x16 grid
   logic       reset0, tick0;
   logic [3:0] hx0, hy0;
   logic [3:0] foodX0, foodY0;
   logic       foodValid0, eaten0;
   logic [7:0] score0;

   // Instance 1: 10x12 grid
   logic       resetG, tickG;
   logic [3:0] hxG, hyG;
   logic [3:0] foodXG, foodYG;
   logic       foodValidG, eatenG;
   logic [7:0] scoreG;

   food_spawner #(.SEED(8'hA5), .GRID_W(16), .GRID_H(16)) dut (
      .clk(clk), .reset(reset0), .tick(tick0), .headX(hx0), .headY(hy0),
      .foodX(foodX0), .foodY(foodY0), .foodValid(foodValid0),
      .eaten(eaten0), .score(score0)
   );

   food_spawner #(.SEED(8'hA5), .GRID_W(10), .GRID_H(12)) dutG (
      .clk(clk), .reset(resetG), .tick(tickG), .headX(hxG), .headY(hyG),
      .foodX(foodXG), .foodY(foodYG), .foodValid(foodValidG),
      .eaten(eatenG), .score(scoreG)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- behavioural model of the game rules ----------------
   int mLfsr   [2];
   int mPlaced [2];
   int mFx     [2];
   int mFy     [2];
   int mEaten  [2];
   int mScore  [2];
   int gridW   [2] = '{16, 10};
   int gridH   [2] = '{16, 12};

   // Fibonacci step: parity of taps 8,6,5,4 shifted into the low bit.
   function automatic int nextLfsr(input int v);
      int taps;
      taps = v & 8'hB8;
      taps = taps ^ (taps >> 4);
      taps = taps ^ (taps >> 2);
      taps = taps ^ (taps >> 1);
      return ((v * 2) % 256) + (taps & 1);
   endfunction

   task automatic modelStep(input int k, input bit rst, input bit tk,
                            input int hx, input int hy);
      int cx, cy;
      if (rst) begin
         mLfsr[k] = 8'hA5; mPlaced[k] = 0; mFx[k] = 0; mFy[k] = 0;
         mEaten[k] = 0;    mScore[k]  = 0;
      end else begin
         cx = mLfsr[k] / 16;
         cy = mLfsr[k] % 16;
         mEaten[k] = 0;
         if (mPlaced[k] == 0) begin
            if (cx < gridW[k] && cy < gridH[k] && !(cx == hx && cy == hy)) begin
               mFx[k] = cx; mFy[k] = cy; mPlaced[k] = 1;
            end
         end else if (tk && hx == mFx[k] && hy == mFy[k]) begin
            mEaten[k]  = 1;
            mScore[k]  = (mScore[k] < 255) ? mScore[k] + 1 : 255;
            mPlaced[k] = 0;
         end
         mLfsr[k] = nextLfsr(mLfsr[k]);
      end
   endtask

   function automatic int packExp(input int k);
      return (mPlaced[k] << 17) | (mFx[k] << 13) | (mFy[k] << 9) |
             (mEaten[k] << 8) | mScore[k];
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: edge, advance both models, sample #1 later, compare.
   task automatic doCycle();
      @(posedge clk);
      modelStep(0, reset0, tick0, int'(hx0), int'(hy0));
      modelStep(1, resetG, tickG, int'(hxG), int'(hyG));
      #1;
      check("model16x16", int'({foodValid0, foodX0, foodY0, eaten0, score0}), packExp(0));
      check("model10x12", int'({foodValidG, foodXG, foodYG, eatenG, scoreG}), packExp(1));
   endtask

   // ---------------- hand-derived vectors for the 16x16 instance ----------------
   typedef struct {
      bit rst; bit tk; int hx; int hy;
      bit fv;  int fx; int fy; bit e; int sc;
   } vec_t;

   vec_t tbl [13];

   initial begin
      // LFSR from A5: A5 4A 95 2A 54 A9 53 ...
      tbl[0]  = '{1, 0,  3, 3,  0,  0, 0, 0, 0};  // reset state
      tbl[1]  = '{0, 0,  3, 3,  1, 10, 5, 0, 0};  // A5 accepted, 1-cycle latency
      tbl[2]  = '{0, 1, 10, 5,  0, 10, 5, 1, 1};  // eat: pulse, score, valid drops
      tbl[3]  = '{0, 0, 10, 5,  1,  9, 5, 0, 1};  // 95 -> (9,5), single pulse
      tbl[4]  = '{0, 0,  9, 5,  1,  9, 5, 0, 1};  // no tick: hold
      tbl[5]  = '{0, 1,  9, 5,  0,  9, 5, 1, 2};  // second eat
      tbl[6]  = '{0, 1,  3, 3,  1, 10, 9, 0, 2};  // tick ignored in PLACE, A9 placed
      tbl[7]  = '{1, 1, 10, 9,  0,  0, 0, 0, 0};  // reset beats matching tick
      tbl[8]  = '{0, 0,  3, 3,  1, 10, 5, 0, 0};  // deterministic replay
      tbl[9]  = '{1, 0, 10, 5,  0,  0, 0, 0, 0};
      tbl[10] = '{0, 0, 10, 5,  0,  0, 0, 0, 0};  // head on seed cell: reject
      tbl[11] = '{0, 0, 10, 5,  1,  4,10, 0, 0};  // 4A -> (4,10)
      tbl[12] = '{0, 1,  3, 3,  1,  4,10, 0, 0};  // tick off-food: no change
   end

   // Watchdog so a stuck run still terminates.
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int spawnsG;
      int cyc;
      int prevPlacedG;
      reset0 = 1'b1; tick0 = 1'b0; hx0 = 4'd3; hy0 = 4'd3;
      resetG = 1'b1; tickG = 1'b0; hxG = 4'd3; hyG = 4'd3;

      // ---- table-driven vectors ----
      for (int i = 0; i < 13; i++) begin
         reset0 = tbl[i].rst; tick0 = tbl[i].tk;
         hx0 = 4'(tbl[i].hx); hy0 = 4'(tbl[i].hy);
         resetG = (i == 0);
         tickG  = 1'($urandom_range(0, 1));
         hxG    = 4'($urandom_range(0, 15));
         hyG    = 4'($urandom_range(0, 15));
         doCycle();
         check($sformatf("vec%0d", i),
               int'({foodValid0, foodX0, foodY0, eaten0, score0}),
               (int'(tbl[i].fv) << 17) | (tbl[i].fx << 13) | (tbl[i].fy << 9) |
               (int'(tbl[i].e) << 8) | tbl[i].sc);
      end

      // ---- randomized play against the model ----
      reset0 = 1'b0; resetG = 1'b0;
      spawnsG = 0;
      cyc = 0;
      while (spawnsG < 500 && cyc < 20000) begin
         if (mPlaced[0] != 0 && $urandom_range(0, 1) == 1) begin
            tick0 = 1'b1; hx0 = 4'(mFx[0]); hy0 = 4'(mFy[0]);
         end else begin
            tick0 = 1'($urandom_range(0, 1));
            hx0 = 4'($urandom_range(0, 15)); hy0 = 4'($urandom_range(0, 15));
         end
         if (mPlaced[1] != 0 && $urandom_range(0, 1) == 1) begin
            tickG = 1'b1; hxG = 4'(mFx[1]); hyG = 4'(mFy[1]);
         end else if (mPlaced[1] == 0 && $urandom_range(0, 3) == 0) begin
            // Head steps onto the pending candidate.
            tickG = 1'($urandom_range(0, 1));
            hxG = 4'(mLfsr[1] / 16); hyG = 4'(mLfsr[1] % 16);
         end else begin
            tickG = 1'($urandom_range(0, 1));
            hxG = 4'($urandom_range(0, 15)); hyG = 4'($urandom_range(0, 15));
         end
         prevPlacedG = mPlaced[1];
         doCycle();
         cyc++;
         if (prevPlacedG == 0 && mPlaced[1] != 0) begin
            spawnsG++;
            check("spawnBoundX", (foodXG <= 4'd9)  ? 1 : 0, 1);
            check("spawnBoundY", (foodYG <= 4'd11) ? 1 : 0, 1);
            check("spawnNotHead", ({foodXG, foodYG} != {hxG, hyG}) ? 1 : 0, 1);
         end
      end
      check("spawnCount500", spawnsG >= 500 ? 1 : 0, 1);

      // ---- score saturation over 260 eats ----
      tickG = 1'b0;
      reset0 = 1'b1; tick0 = 1'b0;
      doCycle();
      reset0 = 1'b0;
      for (int e = 1; e <= 260; e++) begin
         int waitCyc;
         waitCyc = 0;
         tick0 = 1'b0; hx0 = 4'd0; hy0 = 4'd0;  // (0,0) is never a candidate
         while (mPlaced[0] == 0 && waitCyc < 300) begin
            doCycle();
            waitCyc++;
         end
         check("placeInTime", mPlaced[0], 1);
         tick0 = 1'b1; hx0 = 4'(mFx[0]); hy0 = 4'(mFy[0]);
         doCycle();
         check("eatPulse", int'(eaten0), 1);
         check("satScore", int'(score0), (e < 255) ? e : 255);
         check("validDrop", int'(foodValid0), 0);
         tick0 = 1'b0; hx0 = 4'd0; hy0 = 4'd0;
         doCycle();
         check("eatSingle", int'(eaten0), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
